// File: rtl/ca_svm_r_frame_ctrl_if.sv
// rtl/ca_svm_r_frame_ctrl_if.sv - feature/result bus between a sample source, the frame controller and the regressor
//
// Purpose: groups the feature beat stream, the flat regressor input bus, the
// regressor score and the result handshake into one bundle.
// Signals:
//   feat_valid/feat_ready/feat_data/feat_last : feature beat stream into the controller
//   inp                                       : assembled features, slot i at [(i+1)*WIDTH_A-1 : i*WIDTH_A]
//   out_score                                 : regressor score, unsigned fixed point
//   res_valid/res_ready/res_class/res_raw/res_err : result handshake out of the controller
// Modports: master = sample source / result sink, slave = frame controller.
interface ca_svm_r_frame_ctrl_if #(
    parameter int WIDTH_A  = 4,
    parameter int NUM_A    = 21,
    parameter int OUTWIDTH = 14,
    parameter int CLASS_W  = 2
);
    logic                       feat_valid;
    logic                       feat_ready;
    logic [WIDTH_A-1:0]         feat_data;
    logic                       feat_last;
    logic [NUM_A*WIDTH_A-1:0]   inp;
    logic [OUTWIDTH-1:0]        out_score;
    logic                       res_valid;
    logic                       res_ready;
    logic [CLASS_W-1:0]         res_class;
    logic [OUTWIDTH-1:0]        res_raw;
    logic                       res_err;

    modport master (
        output feat_valid, feat_data, feat_last, out_score, res_ready,
        input  feat_ready, inp, res_valid, res_class, res_raw, res_err
    );

    modport slave (
        input  feat_valid, feat_data, feat_last, out_score, res_ready,
        output feat_ready, inp, res_valid, res_class, res_raw, res_err
    );
endinterface

// File: rtl/ca_svm_r_frame_ctrl.sv
// rtl/ca_svm_r_frame_ctrl.sv - frame assembler and result rounder around the SVM regressor
//
// Purpose: collects NUM_A feature beats into the flat regressor input bus,
// waits SETTLE cycles for the combinational regressor, samples its score,
// rounds (ties go down) and clamps it to a class index, and holds the result
// on a valid/ready port until accepted.
// Ports:
//   clk  : clock, all state on the rising edge
//   rst  : synchronous active-high reset
//   bus  : ca_svm_r_frame_ctrl_if slave modport (feature stream, inp,
//          out_score, result handshake)
module ca_svm_r_frame_ctrl #(
    parameter int WIDTH_A   = 4,
    parameter int NUM_A     = 21,
    parameter int OUTWIDTH  = 14,
    parameter int FRAC      = 10,
    parameter int MAX_CLASS = 3,
    parameter int CLASS_W   = 2,
    parameter int SETTLE    = 2
) (
    input  logic clk,
    input  logic rst,
    ca_svm_r_frame_ctrl_if.slave bus
);
    localparam int IDX_W = (NUM_A > 1) ? $clog2(NUM_A + 1) : 1;
    localparam int CNT_W = (SETTLE > 1) ? $clog2(SETTLE) : 1;
    localparam int IP_W  = OUTWIDTH - FRAC + 1;

    localparam logic [IDX_W-1:0] LAST_IDX   = IDX_W'(NUM_A - 1);
    localparam logic [CNT_W-1:0] CNT_LOAD   = CNT_W'(SETTLE - 1);
    localparam logic [FRAC-1:0]  HALF       = {1'b1, {(FRAC-1){1'b0}}};
    localparam logic [IP_W-1:0]  MAX_IP     = IP_W'(MAX_CLASS);

    typedef enum logic [1:0] {
        S_LOAD   = 2'd0,
        S_SETTLE = 2'd1,
        S_RESULT = 2'd2
    } state_t;

    state_t                     r_state;
    state_t                     w_next;
    logic [IDX_W-1:0]           r_idx;
    logic [CNT_W-1:0]           r_cnt;
    logic                       r_err;
    logic [NUM_A*WIDTH_A-1:0]   r_inp;
    logic [OUTWIDTH-1:0]        r_raw;
    logic [CLASS_W-1:0]         r_class;

    logic                       w_feat_ready;
    logic                       w_beat;
    logic                       w_sample;
    logic                       w_res_hs;
    logic                       w_enter_settle;

    logic [IP_W-1:0]            w_ip;
    logic [FRAC-1:0]            w_fr;
    logic                       w_round_up;
    logic [IP_W-1:0]            w_ip_rnd;
    logic [CLASS_W-1:0]         w_class;

    // ------------------------------------------------------------------
    // FSM state register
    // ------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= S_LOAD;
        end else begin
            r_state <= w_next;
        end
    end

    // ------------------------------------------------------------------
    // FSM next state and control strobes
    // ------------------------------------------------------------------
    always_comb begin
        w_next         = r_state;
        w_feat_ready   = 1'b0;
        w_beat         = 1'b0;
        w_sample       = 1'b0;
        w_res_hs       = 1'b0;
        w_enter_settle = 1'b0;
        case (r_state)
            S_LOAD: begin
                // Held low while rst is asserted so no beat is taken in the reset cycle.
                w_feat_ready = ~rst;
                w_beat       = w_feat_ready & bus.feat_valid;
                if (w_beat && (r_idx == LAST_IDX || bus.feat_last)) begin
                    w_enter_settle = 1'b1;
                    w_next         = S_SETTLE;
                end
            end
            S_SETTLE: begin
                if (r_cnt == '0) begin
                    w_sample = 1'b1;
                    w_next   = S_RESULT;
                end
            end
            S_RESULT: begin
                if (bus.res_ready) begin
                    w_res_hs = 1'b1;
                    w_next   = S_LOAD;
                end
            end
            default: begin
                w_next = S_LOAD;
            end
        endcase
    end

    // ------------------------------------------------------------------
    // Score rounding: integer part plus one when the fraction is strictly
    // above one half; the extra top bit of w_ip keeps the increment from
    // wrapping at the largest score.
    // ------------------------------------------------------------------
    always_comb begin
        w_ip       = {1'b0, bus.out_score[OUTWIDTH-1:FRAC]};
        w_fr       = bus.out_score[FRAC-1:0];
        w_round_up = (w_fr > HALF);
        w_ip_rnd   = w_ip + {{(IP_W-1){1'b0}}, w_round_up};
        if (w_ip_rnd > MAX_IP) begin
            w_class = CLASS_W'(MAX_CLASS);
        end else begin
            w_class = w_ip_rnd[CLASS_W-1:0];
        end
    end

    // ------------------------------------------------------------------
    // Datapath: slot writes, framing error, settle counter, result capture
    // ------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (rst) begin
            r_idx   <= '0;
            r_cnt   <= '0;
            r_err   <= 1'b0;
            r_inp   <= '0;
            r_raw   <= '0;
            r_class <= '0;
        end else begin
            if (w_beat) begin
                // Early feat_last zeroes every slot above the current one so
                // stale features from the previous sample never reach the regressor.
                for (int i = 0; i < NUM_A; i++) begin
                    if (IDX_W'(i) == r_idx) begin
                        r_inp[i*WIDTH_A +: WIDTH_A] <= bus.feat_data;
                    end else if (bus.feat_last && (IDX_W'(i) > r_idx)) begin
                        r_inp[i*WIDTH_A +: WIDTH_A] <= '0;
                    end
                end
                r_idx <= r_idx + IDX_W'(1);
                if ((r_idx == LAST_IDX) != bus.feat_last) begin
                    r_err <= 1'b1;
                end
            end

            if (w_enter_settle) begin
                r_cnt <= CNT_LOAD;
            end else if (r_state == S_SETTLE && r_cnt != '0) begin
                r_cnt <= r_cnt - CNT_W'(1);
            end

            if (w_sample) begin
                r_raw   <= bus.out_score;
                r_class <= w_class;
            end

            if (w_res_hs) begin
                r_idx <= '0;
                r_err <= 1'b0;
            end
        end
    end

    assign bus.feat_ready = w_feat_ready;
    assign bus.inp        = r_inp;
    assign bus.res_valid  = (r_state == S_RESULT);
    assign bus.res_class  = r_class;
    assign bus.res_raw    = r_raw;
    assign bus.res_err    = r_err;

endmodule

// File: tb/tb_ca_svm_r_frame_ctrl.sv
// tb/tb_ca_svm_r_frame_ctrl.sv - scoreboard bench for ca_svm_r_frame_ctrl
module tb_ca_svm_r_frame_ctrl;
    localparam int NUM_A = 21;
    localparam int W     = 4;
    localparam int OW    = 14;

    logic clk;
    logic rst;
    int   errors;
    int   checks;

    ca_svm_r_frame_ctrl_if #(.WIDTH_A(W), .NUM_A(NUM_A), .OUTWIDTH(OW), .CLASS_W(2)) bus ();

    ca_svm_r_frame_ctrl dut (
        .clk (clk),
        .rst (rst),
        .bus (bus.slave)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic [1:0]         cls;
        logic [OW-1:0]      raw;
        logic               err;
        logic [NUM_A*W-1:0] inp;
    } exp_t;

    exp_t       sb[$];
    logic [3:0] m_slots[NUM_A];

    function automatic logic [1:0] model_class(input int s);
        int ip;
        int fr;
        ip = s / 1024;
        fr = s % 1024;
        if (fr > 512) ip++;
        if (ip > 3) ip = 3;
        return ip[1:0];
    endfunction

    function automatic logic [NUM_A*W-1:0] model_inp();
        logic [NUM_A*W-1:0] v;
        for (int i = 0; i < NUM_A; i++) v[i*W +: W] = m_slots[i];
        return v;
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Drives n beats back to back, feat_last on beat last_at (-1 = never).
    task automatic send_sample(input int n, input int last_at, input int base, input bit push);
        exp_t e;
        int   w;
        for (int k = 0; k < n; k++) begin
            bus.feat_valid = 1'b1;
            bus.feat_data  = 4'((base + k) % 15 + 1);
            bus.feat_last  = (k == last_at);
            w = 0;
            while (!bus.feat_ready && w < 50) begin
                tick();
                w++;
            end
            if (!bus.feat_ready) begin
                checks++;
                errors++;
                $display("FAIL beat_accept: feat_ready=%0b required 1 at beat %0d", bus.feat_ready, k);
                bus.feat_valid = 1'b0;
                return;
            end
            m_slots[k] = bus.feat_data;
            if (k == last_at) begin
                for (int j = k + 1; j < NUM_A; j++) m_slots[j] = 4'd0;
            end
            tick();
        end
        bus.feat_valid = 1'b0;
        bus.feat_last  = 1'b0;
        if (push) begin
            e.cls = model_class(int'(bus.out_score));
            e.raw = bus.out_score;
            e.err = (last_at != NUM_A - 1);
            e.inp = model_inp();
            sb.push_back(e);
        end
    endtask

    task automatic wait_result();
        exp_t e;
        int   w;
        w = 0;
        while (!bus.res_valid && w < 50) begin
            tick();
            w++;
        end
        checks++;
        if (!bus.res_valid) begin
            errors++;
            $display("FAIL res_timeout: res_valid=%0b required 1", bus.res_valid);
            return;
        end
        checks++;
        if (sb.size() == 0) begin
            errors++;
            $display("FAIL sb_empty: result seen with %0d expected entries required 1", sb.size());
            return;
        end
        e = sb.pop_front();
        checks++;
        if (bus.res_class !== e.cls) begin
            errors++;
            $display("FAIL res_class: got %0d required %0d", bus.res_class, e.cls);
        end
        checks++;
        if (bus.res_raw !== e.raw) begin
            errors++;
            $display("FAIL res_raw: got %0h required %0h", bus.res_raw, e.raw);
        end
        checks++;
        if (bus.res_err !== e.err) begin
            errors++;
            $display("FAIL res_err: got %0b required %0b", bus.res_err, e.err);
        end
        checks++;
        if (bus.inp !== e.inp) begin
            errors++;
            $display("FAIL inp: got %h required %h", bus.inp, e.inp);
        end
        bus.res_ready = 1'b1;
        tick();
        bus.res_ready = 1'b0;
        checks++;
        if (bus.feat_ready !== 1'b1 || bus.res_valid !== 1'b0) begin
            errors++;
            $display("FAIL after_hs: feat_ready=%0b res_valid=%0b required 1 0", bus.feat_ready, bus.res_valid);
        end
    endtask

    task automatic test_reset();
        checks++;
        if (bus.feat_ready !== 1'b0) begin
            errors++;
            $display("FAIL reset_feat_ready: got %0b required 0", bus.feat_ready);
        end
        checks++;
        if (bus.inp !== '0 || bus.res_valid !== 1'b0 || bus.res_class !== 2'd0 ||
            bus.res_raw !== '0 || bus.res_err !== 1'b0) begin
            errors++;
            $display("FAIL reset_outputs: inp=%h valid=%0b class=%0d raw=%0h err=%0b required all 0",
                     bus.inp, bus.res_valid, bus.res_class, bus.res_raw, bus.res_err);
        end
        rst = 1'b0;
        tick();
        checks++;
        if (bus.feat_ready !== 1'b1) begin
            errors++;
            $display("FAIL post_reset_ready: got %0b required 1", bus.feat_ready);
        end
    endtask

    task automatic test_basic_latency();
        bus.out_score = 14'h0800;
        send_sample(NUM_A, NUM_A - 1, 0, 1'b1);
        // now one cycle after the last-beat edge t: cycles t+1, t+2 settle, valid at t+3
        for (int c = 1; c <= 3; c++) begin
            checks++;
            if (bus.res_valid !== (c == 3) || bus.feat_ready !== 1'b0) begin
                errors++;
                $display("FAIL latency_c%0d: res_valid=%0b feat_ready=%0b required %0b 0",
                         c, bus.res_valid, bus.feat_ready, (c == 3));
            end
            if (c < 3) tick();
        end
        wait_result();
    endtask

    task automatic test_rounding();
        logic [OW-1:0] scores[5];
        scores[0] = 14'h0800;
        scores[1] = 14'h0600;
        scores[2] = 14'h0601;
        scores[3] = 14'h0E01;
        scores[4] = 14'h3FFF;
        for (int s = 0; s < 5; s++) begin
            bus.out_score = scores[s];
            send_sample(NUM_A, NUM_A - 1, s * 3, 1'b1);
            wait_result();
        end
    endtask

    task automatic test_early_last();
        bus.out_score = 14'h0A00;
        send_sample(5, 4, 7, 1'b1);
        checks++;
        if (bus.feat_ready !== 1'b0 || bus.inp[NUM_A*W-1:5*W] !== '0) begin
            errors++;
            $display("FAIL early_last: feat_ready=%0b upper_slots=%h required 0 0",
                     bus.feat_ready, bus.inp[NUM_A*W-1:5*W]);
        end
        wait_result();
    endtask

    task automatic test_no_last();
        bus.out_score = 14'h0433;
        send_sample(NUM_A, -1, 2, 1'b1);
        wait_result();
    endtask

    task automatic test_backpressure();
        logic [1:0]    cls0;
        logic [OW-1:0] raw0;
        int            w;
        bus.out_score = 14'h0C7F;
        send_sample(NUM_A, NUM_A - 1, 5, 1'b1);
        w = 0;
        while (!bus.res_valid && w < 50) begin
            tick();
            w++;
        end
        cls0 = model_class(32'h0C7F);
        raw0 = 14'h0C7F;
        for (int c = 0; c < 10; c++) begin
            bus.out_score = 14'($urandom);
            tick();
            checks++;
            if (bus.res_class !== cls0 || bus.res_raw !== raw0 ||
                bus.feat_ready !== 1'b0 || bus.res_valid !== 1'b1) begin
                errors++;
                $display("FAIL hold_c%0d: class=%0d raw=%0h ready=%0b valid=%0b required %0d %0h 0 1",
                         c, bus.res_class, bus.res_raw, bus.feat_ready, bus.res_valid, cls0, raw0);
            end
        end
        wait_result();
    endtask

    task automatic test_reset_mid();
        bus.out_score = 14'h0200;
        send_sample(10, -1, 9, 1'b0);
        rst = 1'b1;
        tick();
        for (int i = 0; i < NUM_A; i++) m_slots[i] = 4'd0;
        checks++;
        if (bus.inp !== '0 || bus.feat_ready !== 1'b0 || bus.res_valid !== 1'b0) begin
            errors++;
            $display("FAIL mid_reset: inp=%h ready=%0b valid=%0b required 0 0 0",
                     bus.inp, bus.feat_ready, bus.res_valid);
        end
        rst = 1'b0;
        tick();
        checks++;
        if (bus.feat_ready !== 1'b1) begin
            errors++;
            $display("FAIL mid_reset_ready: got %0b required 1", bus.feat_ready);
        end
        bus.out_score = 14'h0BFF;
        send_sample(NUM_A, NUM_A - 1, 11, 1'b1);
        wait_result();
    endtask

    initial begin
        errors         = 0;
        checks         = 0;
        rst            = 1'b1;
        bus.feat_valid = 1'b0;
        bus.feat_data  = '0;
        bus.feat_last  = 1'b0;
        bus.out_score  = '0;
        bus.res_ready  = 1'b0;
        for (int i = 0; i < NUM_A; i++) m_slots[i] = 4'd0;
        repeat (2) tick();

        test_reset();
        test_basic_latency();
        test_rounding();
        test_early_last();
        test_no_last();
        test_backpressure();
        test_reset_mid();

        checks++;
        if (sb.size() != 0) begin
            errors++;
            $display("FAIL sb_leftover: %0d entries required 0", sb.size());
        end
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
